// File: rtl/snek_body.sv
// Snake body engine: segment shift register, growth, reversal filter,
// wall/self collision detection and a combinational raster hit test.
module snek_body #(
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned GRID_W  = 32,
  parameter int unsigned GRID_H  = 24,
  parameter int unsigned CELL    = 20,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned START_H = 15,
  parameter int unsigned START_V = 11,
  parameter int unsigned WRAP    = 0
) (
  input  logic               frame_clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [2:0]         dir,
  input  logic               grow,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  output logic               snek_loc,
  output logic               head_loc,
  output logic [COORD_W-1:0] head_h,
  output logic [COORD_W-1:0] head_v,
  output logic [LEN_W-1:0]   length,
  output logic               dead,
  output logic               wall_hit,
  output logic               self_hit
);

  localparam int unsigned PW = 16;

  logic [COORD_W-1:0] seg_h [MAXLEN];
  logic [COORD_W-1:0] seg_v [MAXLEN];
  logic [1:0]         last_dir;

  logic [1:0]         eff_dir;
  logic               do_step;
  logic [COORD_W-1:0] nxt_h;
  logic [COORD_W-1:0] nxt_v;
  logic               wall;
  logic               body;
  logic [LEN_W-1:0]   lim;
  logic [PW-1:0]      lo_h;
  logic [PW-1:0]      lo_v;
  logic [MAXLEN-1:0]  hit;

  assign head_h = seg_h[0];
  assign head_v = seg_v[0];

  // Direction filter, next head, and collision detection.
  always_comb begin
    eff_dir = dir[1:0];
    if (length > LEN_W'(1) && dir[1:0] == (last_dir ^ 2'b01))
      eff_dir = last_dir;
    do_step = run && !dead && !dir[2];
    nxt_h   = seg_h[0];
    nxt_v   = seg_v[0];
    wall    = 1'b0;
    case (eff_dir)
      2'd0: if (seg_h[0] == '0) begin
              nxt_h = COORD_W'(GRID_W - 1);
              wall  = (WRAP == 0);
            end else nxt_h = seg_h[0] - COORD_W'(1);
      2'd1: if (seg_h[0] == COORD_W'(GRID_W - 1)) begin
              nxt_h = '0;
              wall  = (WRAP == 0);
            end else nxt_h = seg_h[0] + COORD_W'(1);
      2'd2: if (seg_v[0] == COORD_W'(GRID_H - 1)) begin
              nxt_v = '0;
              wall  = (WRAP == 0);
            end else nxt_v = seg_v[0] + COORD_W'(1);
      default: if (seg_v[0] == '0) begin
              nxt_v = COORD_W'(GRID_H - 1);
              wall  = (WRAP == 0);
            end else nxt_v = seg_v[0] - COORD_W'(1);
    endcase
    // The tail cell is vacated this step unless the snake grows.
    lim  = grow ? length : length - LEN_W'(1);
    body = 1'b0;
    for (int k = 1; k < int'(MAXLEN); k++)
      if (LEN_W'(k) < lim && seg_h[k] == nxt_h && seg_v[k] == nxt_v)
        body = 1'b1;
  end

  // Raster hit test against every valid segment.
  always_comb begin
    lo_h = '0;
    lo_v = '0;
    hit  = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      lo_h   = PW'(seg_h[i]) * PW'(CELL);
      lo_v   = PW'(seg_v[i]) * PW'(CELL);
      hit[i] = (LEN_W'(i) < length) &&
               (PW'(hpos) >= lo_h) && (PW'(hpos) < lo_h + PW'(CELL)) &&
               (PW'(vpos) >= lo_v) && (PW'(vpos) < lo_v + PW'(CELL));
    end
  end

  assign snek_loc = |hit;
  assign head_loc = hit[0];

  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAXLEN); i++) begin
        seg_h[i] <= (i == 0) ? COORD_W'(START_H) : '0;
        seg_v[i] <= (i == 0) ? COORD_W'(START_V) : '0;
      end
      length   <= LEN_W'(1);
      last_dir <= 2'd1;
      dead     <= 1'b0;
      wall_hit <= 1'b0;
      self_hit <= 1'b0;
    end else if (do_step) begin
      if (wall) begin
        dead     <= 1'b1;
        wall_hit <= 1'b1;
      end else if (body) begin
        dead     <= 1'b1;
        self_hit <= 1'b1;
      end else begin
        last_dir <= eff_dir;
        for (int i = 1; i < int'(MAXLEN); i++) begin
          seg_h[i] <= seg_h[i-1];
          seg_v[i] <= seg_v[i-1];
        end
        seg_h[0] <= nxt_h;
        seg_v[0] <= nxt_v;
        if (grow && length < LEN_W'(MAXLEN))
          length <= length + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_snek_body.sv
// Bench for snek_body: three instances (fatal wall, wrap, MAXLEN=4) share
// stimulus and are checked every cycle against a list-of-cells model.
module tb_snek_body;

  logic       frame_clk;
  logic       rst_n;
  logic       run;
  logic [2:0] dir;
  logic       grow;
  logic [9:0] hpos;
  logic [9:0] vpos;

  logic       o_snek [3];
  logic       o_head [3];
  logic [4:0] o_hh   [3];
  logic [4:0] o_hv   [3];
  logic [7:0] o_len  [3];
  logic       o_dead [3];
  logic       o_wall [3];
  logic       o_self [3];

  int n_tests = 0;
  int n_fail  = 0;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int CS = 20;
  int p_wrap [3] = '{0, 1, 0};
  int p_max  [3] = '{16, 16, 4};

  snek_body #(.WRAP(0), .MAXLEN(16)) u_a (
    .frame_clk(frame_clk), .rst_n(rst_n), .run(run), .dir(dir), .grow(grow),
    .hpos(hpos), .vpos(vpos), .snek_loc(o_snek[0]), .head_loc(o_head[0]),
    .head_h(o_hh[0]), .head_v(o_hv[0]), .length(o_len[0]), .dead(o_dead[0]),
    .wall_hit(o_wall[0]), .self_hit(o_self[0]));

  snek_body #(.WRAP(1), .MAXLEN(16)) u_b (
    .frame_clk(frame_clk), .rst_n(rst_n), .run(run), .dir(dir), .grow(grow),
    .hpos(hpos), .vpos(vpos), .snek_loc(o_snek[1]), .head_loc(o_head[1]),
    .head_h(o_hh[1]), .head_v(o_hv[1]), .length(o_len[1]), .dead(o_dead[1]),
    .wall_hit(o_wall[1]), .self_hit(o_self[1]));

  snek_body #(.WRAP(0), .MAXLEN(4)) u_c (
    .frame_clk(frame_clk), .rst_n(rst_n), .run(run), .dir(dir), .grow(grow),
    .hpos(hpos), .vpos(vpos), .snek_loc(o_snek[2]), .head_loc(o_head[2]),
    .head_h(o_hh[2]), .head_v(o_hv[2]), .length(o_len[2]), .dead(o_dead[2]),
    .wall_hit(o_wall[2]), .self_hit(o_self[2]));

  always #5 frame_clk = ~frame_clk;

  // Model: the body is just the list of occupied cells, head first.
  int m_h [3][17];
  int m_v [3][17];
  int m_len  [3];
  int m_last [3];
  int m_dead [3];
  int m_wall [3];
  int m_self [3];

  function automatic void model_reset(input int n);
    m_len[n] = 1; m_h[n][0] = 15; m_v[n][0] = 11; m_last[n] = 1;
    m_dead[n] = 0; m_wall[n] = 0; m_self[n] = 0;
  endfunction

  function automatic void model_step(input int n);
    int d, nh, nv, lim;
    if (run !== 1'b1 || m_dead[n] != 0 || dir > 3) return;
    d = int'(dir);
    if (m_len[n] > 1 && (d ^ 1) == m_last[n]) d = m_last[n];
    nh = m_h[n][0] + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
    nv = m_v[n][0] + ((d == 2) ? 1 : 0) - ((d == 3) ? 1 : 0);
    if (nh < 0 || nh >= GW || nv < 0 || nv >= GH) begin
      if (p_wrap[n] == 0) begin
        m_dead[n] = 1; m_wall[n] = 1;
        return;
      end
      nh = (nh + GW) % GW;
      nv = (nv + GH) % GH;
    end
    lim = grow ? m_len[n] : m_len[n] - 1;
    for (int k = 1; k < lim; k++)
      if (m_h[n][k] == nh && m_v[n][k] == nv) begin
        m_dead[n] = 1; m_self[n] = 1;
        return;
      end
    m_last[n] = d;
    for (int i = m_len[n]; i > 0; i--) begin
      m_h[n][i] = m_h[n][i-1];
      m_v[n][i] = m_v[n][i-1];
    end
    m_h[n][0] = nh; m_v[n][0] = nv;
    if (grow && m_len[n] < p_max[n]) m_len[n]++;
  endfunction

  function automatic int model_pix(input int n, input int head_only);
    int cnt = head_only ? 1 : m_len[n];
    for (int i = 0; i < cnt; i++)
      if (int'(hpos) / CS == m_h[n][i] && int'(vpos) / CS == m_v[n][i]) return 1;
    return 0;
  endfunction

  always @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) for (int n = 0; n < 3; n++) model_reset(n);
    else        for (int n = 0; n < 3; n++) model_step(n);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge frame_clk) begin
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("u%0d.head_h", n), int'(o_hh[n]), m_h[n][0]);
      chk($sformatf("u%0d.head_v", n), int'(o_hv[n]), m_v[n][0]);
      chk($sformatf("u%0d.length", n), int'(o_len[n]), m_len[n]);
      chk($sformatf("u%0d.dead", n), int'(o_dead[n]), m_dead[n]);
      chk($sformatf("u%0d.wall_hit", n), int'(o_wall[n]), m_wall[n]);
      chk($sformatf("u%0d.self_hit", n), int'(o_self[n]), m_self[n]);
      chk($sformatf("u%0d.snek_loc", n), int'(o_snek[n]), model_pix(n, 0));
      chk($sformatf("u%0d.head_loc", n), int'(o_head[n]), model_pix(n, 1));
    end
  end

  task automatic cyc(input bit r, input int d, input bit g);
    int t;
    run = r; dir = 3'(d); grow = g;
    t = m_h[0][0] * CS - 20 + int'($urandom_range(0, 59));
    hpos = 10'((t < 0) ? 0 : t);
    t = m_v[0][0] * CS - 20 + int'($urandom_range(0, 59));
    vpos = 10'((t < 0) ? 0 : t);
    @(posedge frame_clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge frame_clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    frame_clk = 1'b0; rst_n = 1'b1; run = 1'b0; dir = 3'd1; grow = 1'b0;
    hpos = '0; vpos = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge frame_clk);
    #2 rst_n = 1'b1;
    chk("reset head_h", int'(o_hh[0]), 15);
    chk("reset head_v", int'(o_hv[0]), 11);
    chk("reset length", int'(o_len[0]), 1);
    chk("reset dead", int'(o_dead[0]), 0);

    // Three right steps, plus idle and hold cycles.
    repeat (3) cyc(1, 1, 0);
    cyc(0, 1, 0);
    cyc(1, 5, 0);
    chk("s1 head_h", int'(o_hh[0]), 18);
    chk("s1 head_v", int'(o_hv[0]), 11);
    chk("s1 length", int'(o_len[0]), 1);
    hpos = 10'd365; vpos = 10'd225;
    #1 chk("s1 snek_loc hit", int'(o_snek[0]), 1);
    chk("s1 head_loc hit", int'(o_head[0]), 1);
    hpos = 10'd300;
    #1 chk("s1 snek_loc miss", int'(o_snek[0]), 0);

    // Run into the right wall; wrap instance passes through.
    do_reset();
    repeat (16) cyc(1, 1, 0);
    chk("s2 head_h edge", int'(o_hh[0]), 31);
    chk("s2 dead before", int'(o_dead[0]), 0);
    cyc(1, 1, 0);
    chk("s2 dead", int'(o_dead[0]), 1);
    chk("s2 wall_hit", int'(o_wall[0]), 1);
    chk("s2 head_h held", int'(o_hh[0]), 31);
    chk("s2 wrap head_h", int'(o_hh[1]), 0);
    chk("s2 wrap dead", int'(o_dead[1]), 0);
    repeat (3) cyc(1, 1, 1);
    chk("s2 dead length", int'(o_len[0]), 1);
    chk("s2 dead head_h", int'(o_hh[0]), 31);
    repeat (12) cyc(1, 3, 0);
    chk("s2 wrap head_v", int'(o_hv[1]), 23);

    // Grow to four, reversal filter, then bite the body.
    do_reset();
    repeat (3) cyc(1, 1, 1);
    chk("s3 length", int'(o_len[0]), 4);
    hpos = 10'd310; vpos = 10'd230;
    #1 chk("s3 tail snek_loc", int'(o_snek[0]), 1);
    chk("s3 tail head_loc", int'(o_head[0]), 0);
    cyc(1, 0, 0);
    chk("s3 filtered head_h", int'(o_hh[0]), 19);
    cyc(1, 2, 1);
    cyc(1, 0, 1);
    cyc(1, 3, 1);
    chk("s3 self_hit", int'(o_self[0]), 1);
    chk("s3 dead", int'(o_dead[0]), 1);
    chk("s3 wall_hit", int'(o_wall[0]), 0);
    chk("s3 head_h held", int'(o_hh[0]), 18);
    chk("s3 head_v held", int'(o_hv[0]), 12);

    // Async reset clears dead with no clock edge.
    rst_n = 1'b0;
    #1 chk("s4 async dead", int'(o_dead[0]), 0);
    chk("s4 async self_hit", int'(o_self[0]), 0);
    @(posedge frame_clk);
    #2 rst_n = 1'b1;

    // Square loop chasing the vacating tail.
    repeat (3) cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 2, 0);
    cyc(1, 0, 0);
    cyc(1, 3, 0);
    chk("s4 loop dead", int'(o_dead[0]), 0);
    chk("s4 loop head_h", int'(o_hh[0]), 18);
    chk("s4 loop head_v", int'(o_hv[0]), 11);
    chk("s4 loop length", int'(o_len[0]), 4);

    // Saturating growth, then reset mid-frame.
    do_reset();
    repeat (6) cyc(1, 1, 1);
    chk("s5 sat length", int'(o_len[2]), 4);
    chk("s5 full length", int'(o_len[0]), 7);
    #1 rst_n = 1'b0;
    #1 chk("s5 async length", int'(o_len[2]), 1);
    chk("s5 async head_h", int'(o_hh[2]), 15);
    chk("s5 async head_v", int'(o_hv[2]), 11);
    chk("s5 async length16", int'(o_len[0]), 1);
    @(posedge frame_clk);
    #2 rst_n = 1'b1;
    repeat (2) cyc(1, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snek_body.md
Name: snek_body

Overview:
- Parametrised snake body engine for the snek game.
- Holds up to MAXLEN grid-cell segments and advances them one cell per frame_clk while run is high.
- Grows on request, rejects 180-degree reversals, and detects wall and self collisions (wall behaviour is set by WRAP).
- Sits between the input/direction logic and the pixel mixer; it supplies a combinational body/head hit for the current raster position.

Parameters:
- MAXLEN, 16: maximum segment count, >=2.
- GRID_W, 32: grid columns.
- GRID_H, 24: grid rows.
- CELL, 20: cell size in pixels, both axes.
- COORD_W, 5: coordinate width; must satisfy 2^COORD_W >= max(GRID_W, GRID_H).
- LEN_W, 8: length counter width; must satisfy 2^LEN_W > MAXLEN.
- START_H, 15: head column at reset.
- START_V, 11: head row at reset.
- WRAP, 0: 0 = wall is fatal; 1 = toroidal wrap-around.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  advance enable, sampled each frame_clk.
- dir  in  3  0=left, 1=right, 2=down, 3=up, 4..7=hold (no move).
- grow  in  1  add one segment on this step.
- hpos  in  10  current raster x.
- vpos  in  10  current raster y.
- snek_loc  out  1  raster pixel lies inside any valid segment.
- head_loc  out  1  raster pixel lies inside segment 0.
- head_h  out  COORD_W  head column.
- head_v  out  COORD_W  head row.
- length  out  LEN_W  current valid segment count.
- dead  out  1  sticky collision flag.
- wall_hit  out  1  collision cause was the wall (sticky with dead).
- self_hit  out  1  collision cause was the body (sticky with dead).

Behaviour:
- Reset (async, rst_n=0):
  - seg[0] = (START_H, START_V); all other segments = (0,0), marked invalid.
  - length=1, last_dir=1 (right).
  - dead, wall_hit and self_hit = 0.
- Validity: segment i is valid iff i < length. Invalid segments never drive snek_loc. No sentinel coordinates are used.
- Step condition: a step occurs on a frame_clk edge only when run=1, dead=0 and dir<4 (after reversal filtering). Otherwise all state holds, including grow, which is ignored.
- Reversal filter: when length>1 and dir is the opposite of last_dir (0<->1, 2<->3), eff_dir = last_dir; otherwise eff_dir = dir. last_dir <= eff_dir on each step.
- Next head: add +/-1 on the axis selected by eff_dir.
  - WRAP=0: moving left at h=0, right at h=GRID_W-1, up at v=0 or down at v=GRID_H-1 is a wall collision. No segment moves; dead=1 and wall_hit=1 are set on that edge.
  - WRAP=1: the coordinate wraps modulo GRID_W or GRID_H (0 -> GRID_W-1 and vice versa); no wall collision occurs.
- Self collision: the next head equals old seg[k] for some k in 1..length-2 when not growing, or k in 1..length-1 when growing (the vacating tail is excluded). On hit: no move; dead=1 and self_hit=1. Wall is checked before self, so they are mutually exclusive.
- Normal step:
  - seg[i] <= seg[i-1] for 1<=i<MAXLEN.
  - seg[0] <= next head.
  - If grow=1 and length<MAXLEN: length <= length+1. The new tail takes the old tail coordinate, so the snake gains one segment and the tail stays put.
  - grow at length=MAXLEN: length saturates and the move proceeds normally.
- dead is sticky; only rst_n clears it. A reset mid-game restores the reset state immediately, with no clock needed.
- Pixel test, combinational:
  - in_i = valid_i & (hpos >= h_i*CELL) & (hpos < (h_i+1)*CELL) & (vpos >= v_i*CELL) & (vpos < (v_i+1)*CELL).
  - Compute the products at 10+ bits to avoid overflow.
  - snek_loc = OR of all in_i; head_loc = in_0.
- Outputs head_h, head_v, length, dead, wall_hit and self_hit are registered. Latency from step edge to outputs is 0 cycles after the edge.

Test Plan:
- Reset then 3 steps with run=1, dir=1 -> head (18,11), length 1; probe hpos=365, vpos=225 -> snek_loc=1, head_loc=1; probe hpos=300 -> snek_loc=0.
- WRAP=0: reset, dir=1 for 16 steps -> head (31,11), dead=0. One more step -> dead=1, wall_hit=1, head stays (31,11). Further run cycles and an asserted grow -> nothing changes.
- WRAP=1: same stimulus -> step 17 head (0,11), dead=0. Also dir=3 from v=0 -> v=23.
- grow on 3 consecutive right steps from reset -> length 4, segments (18,11),(17,11),(16,11),(15,11). Then dir=0 -> filtered to right, head (19,11). Then dir=2,0,3 with grow=1 on each -> self_hit=1, dead=1.
- Length-4 square loop (right, down, left, up, no grow) -> head re-enters the vacating tail cell, dead stays 0.
- MAXLEN=4: grow held for 6 steps -> length saturates at 4. Assert rst_n=0 mid-frame -> all outputs return to reset values asynchronously.
